// File: rtl/minirisc_pkg.sv
// Shared definitions for the KGP-miniRISC multiply unit.
// No logic; types and constants only.
// No flow control; consumers import what they need.
package minirisc_pkg;

    // Operand width fixed by the shared 32-bit ripple adder.
    localparam int MUL_WIDTH = 32;
    // One shift-and-add iteration per multiplier bit.
    localparam int MUL_ITERS = 32;
    // Iteration counter width; holds 0..MUL_ITERS-1 plus the wrap.
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/rippleAdder_32bit.sv
// 32-bit ripple-carry adder shared by the multi-cycle multiplier.
// Latency: purely combinational, carry ripples LSB to MSB.
// Backpressure: none; outputs follow inputs.
module rippleAdder_32bit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cinit,
    output logic [31:0] Sum,
    output logic        Cout
);

    // Bit-serial full-adder chain; carry kept in a local variable.
    always_comb begin
        logic carry;
        Sum   = '0;
        carry = Cinit;
        for (int i = 0; i < 32; i++) begin
            Sum[i] = A[i] ^ B[i] ^ carry;
            carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned WIDTHxWIDTH -> 2*WIDTH shift-and-add multiplier on one shared adder.
// Latency: done pulses 33 cycles after start is accepted; busy while not IDLE.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module shift_add_multiplier
    import minirisc_pkg::*;
#(
    // Only 32 is legal: the shared adder is a fixed 32-bit block.
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam logic [MUL_CNT_W-1:0] LAST_ITER = MUL_CNT_W'(MUL_ITERS - 1);

    mul_state_e                 state_q, state_d;
    logic [WIDTH-1:0]           a_q, a_d;
    logic [2*WIDTH-1:0]         acc_q, acc_d;
    logic [MUL_CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]         product_q, product_d;

    logic [WIDTH-1:0]           add_s;
    logic                       add_c;

    // The only adder in the unit: upper accumulator half plus the multiplicand.
    rippleAdder_32bit u_adder (
        .A     (acc_q[2*WIDTH-1:WIDTH]),
        .B     (a_q),
        .Cinit (1'b0),
        .Sum   (add_s),
        .Cout  (add_c)
    );

    // State, operand, accumulator, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state logic: accept in IDLE, one add/shift per RUN cycle, pulse in DONE.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = multiplicand;
                    acc_d   = {{WIDTH{1'b0}}, multiplier};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The adder's carry-out lands in bit 63, so the result is exact.
                if (acc_q[0]) begin
                    acc_d = {add_c, add_s, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + MUL_CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    product_d = acc_d;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product = product_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule
